// File: rtl/imem_boot_loader_pkg.sv
// Shared definitions for the IMem boot loader: FSM states, error codes and helpers.
package mips_boot_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StLenHi,
        StLenLo,
        StPayload,
        StCheck,
        StDone,
        StError
    } state_e;

    localparam logic [1:0] ERR_NONE     = 2'd0;
    localparam logic [1:0] ERR_LEN_ZERO = 2'd1;
    localparam logic [1:0] ERR_LEN_OVF  = 2'd2;
    localparam logic [1:0] ERR_CKSUM    = 2'd3;

    // States in which the loader is consuming the byte stream.
    function automatic logic is_busy(state_e s);
        return (s == StLenHi) || (s == StLenLo) || (s == StPayload) || (s == StCheck);
    endfunction

endpackage

// File: rtl/imem_boot_loader_if.sv
// Host byte link, IMem write port and status signals of the boot loader.
interface imem_boot_loader_if #(
    parameter int unsigned ADDR_WIDTH = 10
);
    logic                  start;
    logic                  rx_valid;
    logic [7:0]            rx_data;
    logic                  rx_ready;
    logic                  imem_we;
    logic [ADDR_WIDTH-1:0] imem_addr;
    logic [31:0]           imem_wdata;
    logic                  cpu_rst;
    logic                  busy;
    logic                  done;
    logic                  error;
    logic [1:0]            err_code;

    modport master (
        output start, rx_valid, rx_data,
        input  rx_ready, imem_we, imem_addr, imem_wdata, cpu_rst, busy, done, error, err_code
    );

    modport slave (
        input  start, rx_valid, rx_data,
        output rx_ready, imem_we, imem_addr, imem_wdata, cpu_rst, busy, done, error, err_code
    );
endinterface

// File: rtl/imem_boot_loader_word_packer.sv
// Packs a big-endian byte stream into 32-bit words; word_valid fires with every 4th byte.
module boot_word_packer (
    input  logic        CLK,
    input  logic        RST,
    input  logic        i_clear,
    input  logic        i_valid,
    input  logic [7:0]  i_byte,
    output logic        o_word_valid,
    output logic [31:0] o_word
);
    logic [23:0] r_shift;
    logic [1:0]  r_cnt;

    always_ff @(posedge CLK) begin
        if (RST || i_clear) begin
            r_shift <= '0;
            r_cnt   <= '0;
        end else if (i_valid) begin
            r_shift <= {r_shift[15:0], i_byte};
            r_cnt   <= r_cnt + 2'd1;
        end
    end

    assign o_word_valid = i_valid && (r_cnt == 2'd3);
    assign o_word       = {r_shift, i_byte};

endmodule

// File: rtl/imem_boot_loader.sv
// Loads a length/payload/checksum byte stream into IMem, then releases the MIPS core reset.
module imem_boot_loader
    import mips_boot_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned BASE_ADDR  = 0
) (
    input  logic               CLK,
    input  logic               RST,
    imem_boot_loader_if.slave  bus
);
    localparam int unsigned MAX_WORDS = 32'd1 << ADDR_WIDTH;

    state_e                r_state, w_state_next;
    logic [1:0]            r_err_code, w_err_next;
    logic [7:0]            r_len_hi;
    logic [15:0]           r_len;
    logic [15:0]           r_words;
    logic [7:0]            r_sum;
    logic                  r_rx_ready, r_we, r_cpu_rst, r_busy, r_done, r_error;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [31:0]           r_wdata;

    logic                  w_hs, w_start_acc, w_pack_valid, w_word_valid;
    logic [15:0]           w_len;
    logic [31:0]           w_word;

    assign w_hs         = bus.rx_valid & r_rx_ready;
    assign w_start_acc  = bus.start &
                          ((r_state == StIdle) || (r_state == StDone) || (r_state == StError));
    assign w_len        = {r_len_hi, bus.rx_data};
    assign w_pack_valid = w_hs && (r_state == StPayload);

    boot_word_packer u_packer (
        .CLK          (CLK),
        .RST          (RST),
        .i_clear      (w_start_acc),
        .i_valid      (w_pack_valid),
        .i_byte       (bus.rx_data),
        .o_word_valid (w_word_valid),
        .o_word       (w_word)
    );

    always_comb begin
        w_state_next = r_state;
        w_err_next   = r_err_code;
        case (r_state)
            StIdle, StDone, StError: begin
                if (w_start_acc) begin
                    w_state_next = StLenHi;
                    w_err_next   = ERR_NONE;
                end
            end
            StLenHi: if (w_hs) w_state_next = StLenLo;
            StLenLo: begin
                if (w_hs) begin
                    if (w_len == 16'd0) begin
                        w_state_next = StError;
                        w_err_next   = ERR_LEN_ZERO;
                    end else if (32'(w_len) > MAX_WORDS) begin
                        w_state_next = StError;
                        w_err_next   = ERR_LEN_OVF;
                    end else begin
                        w_state_next = StPayload;
                    end
                end
            end
            StPayload: begin
                if (w_word_valid && (r_words == r_len - 16'd1)) w_state_next = StCheck;
            end
            StCheck: begin
                if (w_hs) begin
                    if (bus.rx_data == r_sum) begin
                        w_state_next = StDone;
                    end else begin
                        w_state_next = StError;
                        w_err_next   = ERR_CKSUM;
                    end
                end
            end
            default: w_state_next = StIdle;
        endcase
    end

    // Status outputs are registered from the next state so they line up with r_state.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state    <= StIdle;
            r_err_code <= ERR_NONE;
            r_len_hi   <= '0;
            r_len      <= '0;
            r_words    <= '0;
            r_sum      <= '0;
            r_rx_ready <= 1'b0;
            r_we       <= 1'b0;
            r_cpu_rst  <= 1'b1;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_error    <= 1'b0;
            r_addr     <= ADDR_WIDTH'(BASE_ADDR);
            r_wdata    <= '0;
        end else begin
            r_state    <= w_state_next;
            r_err_code <= w_err_next;
            r_rx_ready <= is_busy(w_state_next);
            r_busy     <= is_busy(w_state_next);
            r_done     <= (w_state_next == StDone);
            r_error    <= (w_state_next == StError);
            r_cpu_rst  <= (w_state_next != StDone);
            r_we       <= w_word_valid;
            if (w_hs && (r_state == StLenHi)) r_len_hi <= bus.rx_data;
            if (w_hs && (r_state == StLenLo)) r_len <= w_len;
            if (w_pack_valid) r_sum <= r_sum + bus.rx_data;
            if (w_word_valid) begin
                r_addr  <= ADDR_WIDTH'(BASE_ADDR + 32'(r_words));
                r_wdata <= w_word;
                r_words <= r_words + 16'd1;
            end
            if (w_start_acc) begin
                r_words <= '0;
                r_sum   <= '0;
            end
        end
    end

    assign bus.rx_ready   = r_rx_ready;
    assign bus.imem_we    = r_we;
    assign bus.imem_addr  = r_addr;
    assign bus.imem_wdata = r_wdata;
    assign bus.cpu_rst    = r_cpu_rst;
    assign bus.busy       = r_busy;
    assign bus.done       = r_done;
    assign bus.error      = r_error;
    assign bus.err_code   = r_err_code;

endmodule
